// File: rtl/inj_scan_pkg.sv
// Shared definitions for the injection scan sequencer: states, local register map,
// pulse-generator register offsets and loop-count helpers.
package inj_scan_pkg;

    localparam logic [7:0] VERSION = 8'h01;

    // Local (slave-side) register offsets
    localparam logic [3:0] REG_CTRL       = 4'd0;
    localparam logic [3:0] REG_STATUS     = 4'd1;
    localparam logic [3:0] REG_NFINE      = 4'd2;
    localparam logic [3:0] REG_NCOARSE    = 4'd3;
    localparam logic [3:0] REG_DSTART0    = 4'd4;
    localparam logic [3:0] REG_DSTART1    = 4'd5;
    localparam logic [3:0] REG_DSTART2    = 4'd6;
    localparam logic [3:0] REG_DSTART3    = 4'd7;
    localparam logic [3:0] REG_DSTEP      = 4'd8;
    localparam logic [3:0] REG_GAP0       = 4'd9;
    localparam logic [3:0] REG_GAP1       = 4'd10;
    localparam logic [3:0] REG_TMO0       = 4'd11;
    localparam logic [3:0] REG_TMO1       = 4'd12;
    localparam logic [3:0] REG_FINE_IDX   = 4'd13;
    localparam logic [3:0] REG_COARSE_IDX = 4'd14;

    // Pulse-generator register offsets (master side)
    localparam logic [7:0] TGT_DELAY  = 8'd3;
    localparam logic [7:0] TGT_PHASE  = 8'd15;
    localparam logic [7:0] TGT_START  = 8'd1;
    localparam logic [7:0] TGT_STATUS = 8'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_DLY,
        S_WR_PH,
`ifdef INJ_SCAN_EXT_TRIG_EN
        S_WAIT_TRIG,
`endif
        S_WR_START,
        S_SETTLE,
        S_POLL_RD,
        S_POLL_CHK,
        S_GAP,
        S_NEXT,
        S_FINISH
    } state_t;

    // Fine steps are bounded by the 16-bit phase pattern width.
    function automatic logic [4:0] eff_nfine(input logic [7:0] raw);
        if (raw == 8'd0)
            return 5'd1;
        else if (raw > 8'd16)
            return 5'd16;
        else
            return raw[4:0];
    endfunction

    function automatic logic [7:0] eff_ncoarse(input logic [7:0] raw);
        return (raw == 8'd0) ? 8'd1 : raw;
    endfunction

endpackage

// File: rtl/inj_scan_bus_master.sv
// Master-port driver: registers one write or read strobe per cycle and captures
// the target's read data on the cycle after the read strobe.
module inj_scan_bus_master #(
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_req_i,
    input  logic          rd_req_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [AW-1:0] m_add_o,
    output logic [7:0]    m_data_o,
    output logic          m_wr_o,
    output logic          m_rd_o,
    input  logic [7:0]    m_data_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o
);

    logic [AW-1:0] m_add_q;
    logic [7:0]    m_data_q;
    logic          m_wr_q;
    logic          m_rd_q;
    logic          rd_pend_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_add_q    <= '0;
            m_data_q   <= 8'h00;
            m_wr_q     <= 1'b0;
            m_rd_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            m_wr_q     <= wr_req_i;
            m_rd_q     <= rd_req_i & ~wr_req_i;
            if (wr_req_i || rd_req_i)
                m_add_q <= addr_i;
            if (wr_req_i)
                m_data_q <= wdata_i;
            // Target presents read data in the cycle following M_RD.
            rd_pend_q  <= m_rd_q;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q)
                rd_data_q <= m_data_i;
        end
    end

    assign m_add_o    = m_add_q;
    assign m_data_o   = m_data_q;
    assign m_wr_o     = m_wr_q;
    assign m_rd_o     = m_rd_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/inj_scan_sequencer.sv
// 2-D injection scan controller (coarse DELAY x fine PHASE) driving the pulse generator.
// Optional INJ_SCAN_EXT_TRIG_EN adds EXT_TRIG and waits for its rising edge before each START.
module inj_scan_sequencer
    import inj_scan_pkg::*;
#(
    parameter int                   ABUSWIDTH   = 16,
    parameter logic [ABUSWIDTH-1:0] TARGET_BASE = '0,
    parameter int                   SETTLE      = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
`ifdef INJ_SCAN_EXT_TRIG_EN
    input  logic                 EXT_TRIG,
`endif
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    output logic [ABUSWIDTH-1:0] M_ADD,
    output logic [7:0]           M_DATA_OUT,
    input  logic [7:0]           M_DATA_IN,
    output logic                 M_WR,
    output logic                 M_RD,
    output logic                 BUSY
);

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [1:0]  byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] to_q, to_d;
    logic [3:0]  fine_q, fine_d;
    logic [7:0]  coarse_q, coarse_d;
    logic [31:0] acc_q, acc_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [7:0]  nfine_q, ncoarse_q, dstep_q, rdata_q;
    logic [31:0] dstart_q;
    logic [15:0] gap_q, tmo_q;

    logic                 local_sel, soft_rst, start_wr, cfg_wr, rst_all;
    logic                 wr_req, rd_req, rd_valid, timing, last_fine, last_coarse;
    logic [7:0]           m_off, m_wdata, rd_data, rd_mux;
    logic [15:0]          phase;
    logic [ABUSWIDTH-1:0] m_addr;
    logic                 unused_rd_bits;

    assign local_sel = (BUS_ADD[ABUSWIDTH-1:4] == '0);
    assign soft_rst  = BUS_WR && local_sel && (BUS_ADD[3:0] == REG_CTRL);
    assign start_wr  = BUS_WR && local_sel && (BUS_ADD[3:0] == REG_STATUS);
    assign cfg_wr    = BUS_WR && local_sel && !BUSY;
    assign rst_all   = BUS_RST || soft_rst;
    assign BUSY      = (state_q != S_IDLE);

    assign phase       = 16'hFFFF << fine_q;
    assign last_fine   = ({1'b0, fine_q} == (eff_nfine(nfine_q) - 5'd1));
    assign last_coarse = (coarse_q == (eff_ncoarse(ncoarse_q) - 8'd1));
    assign timing      = (state_q == S_SETTLE) || (state_q == S_POLL_RD) || (state_q == S_POLL_CHK);
    assign m_addr      = TARGET_BASE + {{(ABUSWIDTH-8){1'b0}}, m_off};
    assign unused_rd_bits = ^rd_data[7:1];

    always_comb begin
        rd_mux = 8'h00;
        if (local_sel) begin
            case (BUS_ADD[3:0])
                REG_CTRL:       rd_mux = VERSION;
                REG_STATUS:     rd_mux = {6'b0, error_q, done_q};
                REG_NFINE:      rd_mux = nfine_q;
                REG_NCOARSE:    rd_mux = ncoarse_q;
                REG_DSTART0:    rd_mux = dstart_q[7:0];
                REG_DSTART1:    rd_mux = dstart_q[15:8];
                REG_DSTART2:    rd_mux = dstart_q[23:16];
                REG_DSTART3:    rd_mux = dstart_q[31:24];
                REG_DSTEP:      rd_mux = dstep_q;
                REG_GAP0:       rd_mux = gap_q[7:0];
                REG_GAP1:       rd_mux = gap_q[15:8];
                REG_TMO0:       rd_mux = tmo_q[7:0];
                REG_TMO1:       rd_mux = tmo_q[15:8];
                REG_FINE_IDX:   rd_mux = {4'b0, fine_q};
                REG_COARSE_IDX: rd_mux = coarse_q;
                default:        rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst_all) begin
            nfine_q   <= 8'd1;
            ncoarse_q <= 8'd1;
            dstart_q  <= 32'h0;
            dstep_q   <= 8'h00;
            gap_q     <= 16'h0;
            tmo_q     <= 16'h0;
            rdata_q   <= 8'h00;
        end else begin
            if (cfg_wr) begin
                case (BUS_ADD[3:0])
                    REG_NFINE:   nfine_q          <= BUS_DATA_IN;
                    REG_NCOARSE: ncoarse_q        <= BUS_DATA_IN;
                    REG_DSTART0: dstart_q[7:0]    <= BUS_DATA_IN;
                    REG_DSTART1: dstart_q[15:8]   <= BUS_DATA_IN;
                    REG_DSTART2: dstart_q[23:16]  <= BUS_DATA_IN;
                    REG_DSTART3: dstart_q[31:24]  <= BUS_DATA_IN;
                    REG_DSTEP:   dstep_q          <= BUS_DATA_IN;
                    REG_GAP0:    gap_q[7:0]       <= BUS_DATA_IN;
                    REG_GAP1:    gap_q[15:8]      <= BUS_DATA_IN;
                    REG_TMO0:    tmo_q[7:0]       <= BUS_DATA_IN;
                    REG_TMO1:    tmo_q[15:8]      <= BUS_DATA_IN;
                    default: ;
                endcase
            end
            if (BUS_RD)
                rdata_q <= rd_mux;
        end
    end

    assign BUS_DATA_OUT = rdata_q;

`ifdef INJ_SCAN_EXT_TRIG_EN
    logic trig_q;
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST)
            trig_q <= 1'b0;
        else
            trig_q <= EXT_TRIG;
    end
`endif

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        fine_d   = fine_q;
        coarse_d = coarse_q;
        acc_d    = acc_q;
        done_d   = done_q;
        error_d  = error_q;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        m_off    = 8'h00;
        m_wdata  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    state_d  = S_WR_DLY;
                    byte_d   = 2'd0;
                    fine_d   = 4'd0;
                    coarse_d = 8'd0;
                    acc_d    = dstart_q;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                end
            end
            S_WR_DLY: begin
                wr_req  = 1'b1;
                m_off   = TGT_DELAY + {6'b0, byte_q};
                m_wdata = acc_q[{byte_q, 3'b000} +: 8];
                byte_d  = byte_q + 2'd1;
                if (byte_q == 2'd3)
                    state_d = S_WR_PH;
            end
            S_WR_PH: begin
                wr_req  = 1'b1;
                m_off   = TGT_PHASE + {7'b0, byte_q[0]};
                m_wdata = byte_q[0] ? phase[15:8] : phase[7:0];
                byte_d  = byte_q + 2'd1;
                if (byte_q[0]) begin
                    byte_d = 2'd0;
`ifdef INJ_SCAN_EXT_TRIG_EN
                    state_d = S_WAIT_TRIG;
`else
                    state_d = S_WR_START;
`endif
                end
            end
`ifdef INJ_SCAN_EXT_TRIG_EN
            S_WAIT_TRIG: begin
                if (EXT_TRIG && !trig_q)
                    state_d = S_WR_START;
            end
`endif
            S_WR_START: begin
                wr_req  = 1'b1;
                m_off   = TGT_START;
                m_wdata = 8'h01;
                to_d    = {tmo_q, 8'h00};
                cnt_d   = SETTLE_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 16'h0)
                    state_d = S_POLL_RD;
                else
                    cnt_d = cnt_q - 16'd1;
            end
            S_POLL_RD: begin
                rd_req  = 1'b1;
                m_off   = TGT_STATUS;
                state_d = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                if (rd_valid) begin
                    if (!rd_data[0]) begin
                        state_d = S_POLL_RD;
                    end else if (gap_q == 16'h0) begin
                        state_d = S_NEXT;
                    end else begin
                        cnt_d   = gap_q - 16'd1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 16'h0)
                    state_d = S_NEXT;
                else
                    cnt_d = cnt_q - 16'd1;
            end
            S_NEXT: begin
                if (!last_fine) begin
                    fine_d  = fine_q + 4'd1;
                    state_d = S_WR_DLY;
                end else if (!last_coarse) begin
                    fine_d   = 4'd0;
                    coarse_d = coarse_q + 8'd1;
                    acc_d    = acc_q + {24'h0, dstep_q};
                    state_d  = S_WR_DLY;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Step timeout spans START through DONE; a zero TIMEOUT disables it.
        if (timing && (tmo_q != 16'h0)) begin
            if (to_q == 24'h0) begin
                state_d = S_IDLE;
                error_d = 1'b1;
                done_d  = 1'b1;
                rd_req  = 1'b0;
            end else begin
                to_d = to_q - 24'd1;
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst_all) begin
            state_q  <= S_IDLE;
            byte_q   <= 2'd0;
            cnt_q    <= 16'h0;
            to_q     <= 24'h0;
            fine_q   <= 4'd0;
            coarse_q <= 8'd0;
            acc_q    <= 32'h0;
            done_q   <= 1'b1;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            fine_q   <= fine_d;
            coarse_q <= coarse_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    inj_scan_bus_master #(
        .AW (ABUSWIDTH)
    ) u_master (
        .clk_i      (BUS_CLK),
        .rst_i      (rst_all),
        .wr_req_i   (wr_req),
        .rd_req_i   (rd_req),
        .addr_i     (m_addr),
        .wdata_i    (m_wdata),
        .m_add_o    (M_ADD),
        .m_data_o   (M_DATA_OUT),
        .m_wr_o     (M_WR),
        .m_rd_o     (M_RD),
        .m_data_i   (M_DATA_IN),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid)
    );

endmodule
